// File: rtl/if_stage.sv
// Instruction fetch stage: sequential PC, one-cycle memory interface, 2-entry {pc,inst} buffer to ID.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirects raise fetch_misalign_o and halt fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        id_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_data_o,
  output logic        fetch_misalign_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        inflight_q, inflight_d;
  logic        misalign_q, misalign_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] fpc_q [2];
  logic [31:0] fpc_d [2];
  logic [31:0] finst_q [2];
  logic [31:0] finst_d [2];

  logic [31:0] tgt;
  logic        tgt_bad;
  logic        deq, enq, issue;
  logic [2:0]  occupancy;
  logic [1:0]  wr_idx;
  logic [31:0] addr;

  always_comb begin
`ifdef IF_MISALIGN_TRAP_EN
    tgt     = redirect_addr_i;
    tgt_bad = |redirect_addr_i[1:0];
`else
    tgt     = {redirect_addr_i[31:2], 2'b00};
    tgt_bad = 1'b0;
`endif
    deq       = (count_q != 2'd0) && id_ready_i;
    enq       = inflight_q && !redirect_i;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};

    // Redirect overrides everything: flush, drop the arriving response, fetch target now.
    if (redirect_i) begin
      issue = !tgt_bad;
      addr  = tgt;
    end else begin
      issue = !misalign_q && (occupancy < 3'd2);
      addr  = pc_q;
    end

    pc_d       = redirect_i ? tgt + 32'd4 : (issue ? pc_q + 32'd4 : pc_q);
    inflight_d = issue;
    req_pc_d   = addr;
    misalign_d = redirect_i ? tgt_bad : misalign_q;

    fpc_d   = fpc_q;
    finst_d = finst_q;
    wr_idx  = count_q - {1'b0, deq};
    if (deq) begin
      fpc_d[0]   = fpc_q[1];
      finst_d[0] = finst_q[1];
    end
    if (enq) begin
      fpc_d[wr_idx[0]]   = req_pc_q;
      finst_d[wr_idx[0]] = imem_data_i;
    end

    if (redirect_i) count_d = 2'd0;
    else            count_d = count_q - {1'b0, deq} + {1'b0, enq};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      misalign_q <= misalign_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q/inflight_q alone.
  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
    fpc_q    <= fpc_d;
    finst_q  <= finst_d;
  end

  assign imem_en_o        = issue && !rst;
  assign imem_addr_o      = addr;
  assign inst_valid_o     = (count_q != 2'd0);
  assign inst_o           = inst_valid_o ? finst_q[0] : NOP;
  assign pc_data_o        = inst_valid_o ? fpc_q[0] : 32'd0;
  assign fetch_misalign_o = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a queue-based fetch model, with directed scenarios
// for start-up, back-pressure, redirects, misalignment, PC wrap and mid-stream reset.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i = 32'd0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = 32'd0;
  logic        id_ready_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_data_o;
  logic        fetch_misalign_o;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_en_o(imem_en_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .id_ready_i(id_ready_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_data_o(pc_data_o),
    .fetch_misalign_o(fetch_misalign_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state: buffered PCs in order, the pending request, next sequential PC, trap flag.
  logic [31:0] q[$];
  logic        m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_pc;
  logic        m_mis;
  // Model outputs for the current cycle.
  logic        m_en, m_valid, m_deq, m_bad;
  logic [31:0] m_addr, m_inst, m_pcd, m_tgt;
  // DUT samples of the current cycle.
  logic        s_en, s_valid, s_mis;
  logic [31:0] s_addr, s_inst, s_pcd;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_infl = 1'b0; m_infl_pc = 32'd0; m_pc = RST_PC; m_mis = 1'b0;
  endtask

  task automatic model_comb();
    m_valid = (q.size() != 0);
    m_deq   = m_valid && id_ready_i;
    m_pcd   = m_valid ? q[0] : 32'd0;
    m_inst  = m_valid ? mem(q[0]) : NOP;
`ifdef IF_MISALIGN_TRAP_EN
    m_tgt = redirect_addr_i;
    m_bad = (redirect_addr_i[1:0] != 2'b00);
`else
    m_tgt = redirect_addr_i & 32'hFFFF_FFFC;
    m_bad = 1'b0;
`endif
    if (redirect_i) begin
      m_en = !m_bad; m_addr = m_tgt;
    end else begin
      m_en = !m_mis && ((q.size() + int'(m_infl) - int'(m_deq)) < 2);
      m_addr = m_pc;
    end
  endtask

  task automatic model_edge();
    if (redirect_i) begin
      q.delete();
      m_pc  = m_tgt + 32'd4;
      m_mis = m_bad;
    end else begin
      if (m_deq) void'(q.pop_front());
      if (m_infl) q.push_back(m_infl_pc);
      if (m_en) m_pc = m_pc + 32'd4;
    end
    m_infl    = m_en;
    m_infl_pc = m_addr;
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] raddr);
    id_ready_i = rdy; redirect_i = redir; redirect_addr_i = raddr;
    #1;
    model_comb();
    s_en = imem_en_o; s_addr = imem_addr_o; s_valid = inst_valid_o;
    s_inst = inst_o; s_pcd = pc_data_o; s_mis = fetch_misalign_o;
    chk("imem_en", {31'd0, s_en}, {31'd0, m_en});
    if (m_en) chk("imem_addr", s_addr, m_addr);
    else      chk("idle_addr", s_addr, m_addr);
    chk("inst_valid", {31'd0, s_valid}, {31'd0, m_valid});
    chk("inst", s_inst, m_inst);
    chk("pc_data", s_pcd, m_pcd);
    chk("misalign", {31'd0, s_mis}, {31'd0, m_mis});
    @(posedge clk);
    model_edge();
    #1;
    imem_data_i = m_infl ? mem(m_infl_pc) : $urandom;
    @(negedge clk);
    redirect_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"},    {31'd0, imem_en_o},        32'd0);
    chk({tag, "_valid"}, {31'd0, inst_valid_o},     32'd0);
    chk({tag, "_inst"},  inst_o,                    NOP);
    chk({tag, "_pc"},    pc_data_o,                 32'd0);
    chk({tag, "_mis"},   {31'd0, fetch_misalign_o}, 32'd0);
  endtask

  logic [31:0] held_pc;
  logic [31:0] ra;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_init");
    rst = 1'b0;

    // Start-up with ID always ready.
    cycle(1'b1, 1'b0, 32'd0);
    chk("first_addr", s_addr, 32'h4000_0000);
    chk("first_en", {31'd0, s_en}, 32'd1);
    cycle(1'b1, 1'b0, 32'd0);
    chk("second_addr", s_addr, 32'h4000_0004);
    chk("no_early_valid", {31'd0, s_valid}, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    chk("first_valid_pc", s_pcd, 32'h4000_0000);
    chk("first_valid_inst", s_inst, mem(32'h4000_0000));
    cycle(1'b1, 1'b0, 32'd0);
    chk("second_valid_pc", s_pcd, 32'h4000_0004);
    repeat (4) cycle(1'b1, 1'b0, 32'd0);

    // Back-pressure for 5 cycles: buffer fills, fetch stops, head stays put.
    cycle(1'b0, 1'b0, 32'd0);
    held_pc = s_pcd;
    repeat (4) cycle(1'b0, 1'b0, 32'd0);
    chk("stall_head_pc", s_pcd, held_pc);
    chk("stall_no_fetch", {31'd0, s_en}, 32'd0);
    repeat (4) cycle(1'b1, 1'b0, 32'd0);

    // Fill, then redirect in the same cycle as a dequeue.
    repeat (3) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h4000_0100);
    chk("redir_addr", s_addr, 32'h4000_0100);
    chk("redir_en", {31'd0, s_en}, 32'd1);
    cycle(1'b1, 1'b0, 32'd0);
    chk("redir_flushed", {31'd0, s_valid}, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    chk("redir_target_pc", s_pcd, 32'h4000_0100);
    repeat (3) cycle(1'b1, 1'b0, 32'd0);

    // Misaligned redirect.
    cycle(1'b1, 1'b1, 32'h4000_0102);
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_no_fetch", {31'd0, s_en}, 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    chk("mis_flag", {31'd0, s_mis}, 32'd1);
    chk("mis_halted", {31'd0, s_en}, 32'd0);
`else
    chk("mis_aligned_addr", s_addr, 32'h4000_0100);
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    chk("mis_flag_tied", {31'd0, s_mis}, 32'd0);
`endif

    // Aligned redirect near the top of the address space: PC wraps.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    chk("wrap_redir", s_addr, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b0, 32'd0);
    chk("mis_cleared", {31'd0, s_mis}, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    chk("wrap_addr", s_addr, 32'h0000_0000);
    repeat (4) cycle(1'b1, 1'b0, 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      ra = 32'h4000_0000 | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 7) == 0) ra = ra | 32'd2;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, ra);
    end

    // Mid-stream reset with a full buffer.
    repeat (4) cycle(1'b1, 1'b1, 32'h4000_0200);
    repeat (4) cycle(1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    model_reset();
    rst = 1'b0;
    cycle(1'b1, 1'b0, 32'd0);
    chk("restart_addr", s_addr, RST_PC);
    repeat (6) cycle(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 100; i++)
      cycle($urandom_range(0, 1) != 0, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000, the first fetch address after reset.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_en_o  out  1  fetch request this cycle.
- imem_addr_o  out  32  byte address of the request.
- imem_data_i  in  32  instruction word, valid exactly one cycle after imem_en_o.
- redirect_i  in  1  branch/jump taken; flush and refetch.
- redirect_addr_i  in  32  redirect target.
- id_ready_i  in  1  ID accepts inst_o this cycle.
- inst_valid_o  out  1  inst_o/pc_data_o hold a valid entry.
- inst_o  out  32  instruction to ID; 32'h0000_0013 (NOP) when invalid.
- pc_data_o  out  32  PC of inst_o; 0 when invalid.
- fetch_misalign_o  out  1  misaligned-redirect flag (see Configuration).

Function
REQ-003 SHALL hold a 32-bit fetch PC, a 2-entry {pc,inst} FIFO, and one in-flight flag (request issued last cycle).
REQ-004 SHALL dequeue when inst_valid_o & id_ready_i; inst_valid_o = FIFO not empty; inst_o/pc_data_o come from the FIFO head.
REQ-005 SHALL issue when (count + inflight - deq) < 2 and not halted; on issue imem_addr_o = PC, and PC <= PC + 4 (wraps modulo 2^32).
REQ-006 SHALL, when imem_en_o is low, drive imem_addr_o = PC.
REQ-007 SHALL write imem_data_i with its request PC into the FIFO tail in the cycle after an issue, unless it is discarded under REQ-008.
REQ-008 SHALL treat redirect_i as highest priority; in that cycle:
- empty the FIFO, including an entry being dequeued in the same cycle;
- discard the response arriving in that cycle;
- issue redirect_addr_i combinationally on imem_addr_o;
- set PC <= redirect_addr_i + 4.
REQ-009 SHALL make issue-to-inst_valid_o latency 2 cycles (request N, response N+1, visible N+2); no bypass.
REQ-010 SHALL sustain one instruction per cycle while id_ready_i is held high.
REQ-011 SHALL, while id_ready_i is low and the FIFO is full, stop issuing and hold the head stable; no entry is ever lost or duplicated.
REQ-012 SHALL keep simultaneous enqueue and dequeue at count unchanged, with order preserved.

Reset
REQ-013 SHALL, while rst is high, force:
- PC = RESET_PC; FIFO empty; inflight = 0;
- imem_en_o = 0, inst_valid_o = 0;
- inst_o = NOP, pc_data_o = 0, fetch_misalign_o = 0.
REQ-014 SHALL issue RESET_PC in the first cycle after rst deasserts.
REQ-015 SHALL, if rst asserts mid-operation, drop all buffered and in-flight instructions with no late write.

Configuration
REQ-016 SHALL, with IF_MISALIGN_TRAP_EN defined, on a redirect with redirect_addr_i[1:0] != 0:
- set fetch_misalign_o and halt issuing;
- keep the FIFO empty;
- hold the flag until the next aligned redirect or reset.
REQ-017 SHALL, without IF_MISALIGN_TRAP_EN:
- force redirect_addr_i[1:0] to 0 before use;
- tie fetch_misalign_o to 0.

Verification
REQ-018 Reset release, id_ready_i = 1 -> imem_addr_o sequence 4000_0000, 4000_0004, ...; first inst_valid_o two cycles after the first issue, then one instruction per cycle.
REQ-019 Hold id_ready_i = 0 for 5 cycles -> count reaches 2, imem_en_o drops, head PC stable; after release, PCs continue in order with no gap or duplicate.
REQ-020 Redirect to 4000_0100 while the FIFO holds 2 entries and a request is in flight -> old entries never appear on the output; next valid pc_data_o = 4000_0100 two cycles later.
REQ-021 Redirect in the same cycle as a dequeue -> dequeued and buffered entries dropped; redirect target fetched that cycle.
REQ-022 Redirect to 4000_0102 -> with the macro: fetch_misalign_o = 1 and imem_en_o = 0 until an aligned redirect; without it: fetch from 4000_0100.
REQ-023 Assert rst mid-stream with 2 entries buffered -> outputs at reset values immediately; after release, fetch restarts at RESET_PC.
